// File: rtl/qrisc32_pkg.sv
// qrisc32_pkg
//   Shared types and defaults for the qrisc32 memory arbiter.
//   arb_state_t          : arbiter FSM state encoding
//   ARB_DEF_MAX_D_BURST  : default number of consecutive data grants
//                          before a forced instruction grant (fairness build)
package qrisc32_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_t;

  localparam int ARB_DEF_MAX_D_BURST = 4;

endpackage

// File: rtl/avalon_port.sv
// avalon_port
//   Minimal Avalon-MM style bundle shared by the pipeline masters and memory.
//   address_r, rd, wr, data_w : master -> slave
//   data_r, wait_req          : slave -> master
//   modport mst : the side issuing requests
//   modport slv : the side answering requests
interface avalon_port #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] address_r;
  logic          rd;
  logic          wr;
  logic [DW-1:0] data_w;
  logic [DW-1:0] data_r;
  logic          wait_req;

  modport mst (output address_r, output rd, output wr, output data_w,
               input  data_r,    input  wait_req);
  modport slv (input  address_r, input  rd, input  wr, input  data_w,
               output data_r,    output wait_req);
endinterface

// File: rtl/qrisc32_mem_arbiter.sv
// qrisc32_mem_arbiter
//   Shares one memory port between the IF stage (instruction reads) and the
//   MEM stage (data reads/writes). Data wins by default; a transfer stalled
//   by the memory keeps ownership until it completes. The losing requester
//   sees wait_req=1 and stalls through its normal wait path.
//
//   Ports
//     clk        : clock
//     areset_n   : asynchronous active-low reset
//     avm_instr  : slave side facing IF  (address_r, rd in; data_r, wait_req out)
//     avm_data   : slave side facing MEM (address_r, rd, wr, data_w in; data_r, wait_req out)
//     avm_mem    : master side facing memory
//     grant_data : 1 while the data master owns avm_mem
//
//   Build option
//     QRISC32_ARB_FAIRNESS_EN : after MAX_D_BURST consecutive data transfers
//     with IF waiting, the next idle-state grant goes to IF.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ARB_IDLE   | no held transfer; winner picked combinationally
//   ARB_LOCK_I | IF transfer stalled by memory; IF keeps the port
//   ARB_LOCK_D | MEM transfer stalled by memory; MEM keeps the port
module qrisc32_mem_arbiter
  import qrisc32_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_D_BURST = ARB_DEF_MAX_D_BURST
) (
  input  logic    clk,
  input  logic    areset_n,
  avalon_port.slv avm_instr,
  avalon_port.slv avm_data,
  avalon_port.mst avm_mem,
  output logic    grant_data
);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          instr_req;
  logic          data_req;
  logic          own_i;
  logic          own_d;
  logic          force_instr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic          i_wait;
  logic          d_wait;
  logic [DW-1:0] rdata_bcast;
  logic          gnt_d;

  // IF never writes; its write-side signals are intentionally ignored.
  logic unused_instr_wr_side;
  assign unused_instr_wr_side = avm_instr.wr ^ (^avm_instr.data_w);

`ifdef QRISC32_ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_D_BURST + 1);
  logic [SW-1:0] d_streak;
  logic          done_i;
  logic          done_d;
`else
  localparam int UNUSED_MAX_D_BURST = MAX_D_BURST;
`endif

  always_comb begin
    instr_req   = avm_instr.rd;
    data_req    = avm_data.rd | avm_data.wr;
    own_i       = 1'b0;
    own_d       = 1'b0;
    force_instr = 1'b0;
`ifdef QRISC32_ARB_FAIRNESS_EN
    force_instr = instr_req && (d_streak == SW'(MAX_D_BURST));
`endif
    case (state)
      ARB_IDLE: begin
        if (data_req && !force_instr) own_d = 1'b1;
        else if (instr_req)           own_i = 1'b1;
      end
      // A locked owner that drops its request releases the port with no
      // grant to anyone this cycle, so the memory sees rd=wr=0.
      ARB_LOCK_I: own_i = instr_req;
      ARB_LOCK_D: own_d = data_req;
      default: ;
    endcase

    // Reset masks ownership asynchronously so outputs settle without clk.
    if (!areset_n) begin
      own_i = 1'b0;
      own_d = 1'b0;
    end

    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (own_d) begin
      mem_addr  = avm_data.address_r;
      mem_wdata = avm_data.data_w;
      mem_rd    = avm_data.rd;
      mem_wr    = avm_data.wr;
    end else if (own_i) begin
      mem_addr  = avm_instr.address_r;
      mem_rd    = avm_instr.rd;
    end

    i_wait = own_i ? avm_mem.wait_req : instr_req;
    d_wait = own_d ? avm_mem.wait_req : data_req;
    rdata_bcast = avm_mem.data_r;
    if (!areset_n) begin
      i_wait      = 1'b1;
      d_wait      = 1'b1;
      rdata_bcast = '0;
    end
    gnt_d = own_d;

    state_nxt = ARB_IDLE;
    if (own_i && avm_mem.wait_req)      state_nxt = ARB_LOCK_I;
    else if (own_d && avm_mem.wait_req) state_nxt = ARB_LOCK_D;

`ifdef QRISC32_ARB_FAIRNESS_EN
    done_i = own_i && !avm_mem.wait_req;
    done_d = own_d && !avm_mem.wait_req;
`endif
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= ARB_IDLE;
`ifdef QRISC32_ARB_FAIRNESS_EN
      d_streak <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef QRISC32_ARB_FAIRNESS_EN
      if (done_i)
        d_streak <= '0;
      else if (done_d && instr_req && (d_streak != SW'(MAX_D_BURST)))
        d_streak <= d_streak + 1'b1;
`endif
    end
  end

  assign avm_mem.address_r  = mem_addr;
  assign avm_mem.data_w     = mem_wdata;
  assign avm_mem.rd         = mem_rd;
  assign avm_mem.wr         = mem_wr;
  assign avm_instr.wait_req = i_wait;
  assign avm_data.wait_req  = d_wait;
  assign avm_instr.data_r   = rdata_bcast;
  assign avm_data.data_r    = rdata_bcast;
  assign grant_data         = gnt_d;

endmodule

// File: tb/tb_qrisc32_mem_arbiter.sv
// tb_qrisc32_mem_arbiter
//   Directed bench for qrisc32_mem_arbiter: a cycle-by-cycle vector table for
//   contention, lock hold and owner drop, plus hand-written sequences for
//   reset, the data/instr grant pattern under continuous traffic, and an
//   asynchronous reset in the middle of a locked data transfer.
module tb_qrisc32_mem_arbiter;

  typedef struct {
    logic        i_rd;
    logic [31:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_wait;
    logic [31:0] m_rdata;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iw;
    logic        e_dw;
    logic        e_g;
  } vec_t;

  logic clk = 1'b0;
  logic areset_n;
  logic grant_data;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  avalon_port #(.AW(32), .DW(32)) i_if ();
  avalon_port #(.AW(32), .DW(32)) d_if ();
  avalon_port #(.AW(32), .DW(32)) m_if ();

  qrisc32_mem_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(4)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .avm_instr  (i_if),
    .avm_data   (d_if),
    .avm_mem    (m_if),
    .grant_data (grant_data)
  );

  function automatic vec_t mkv(
    input logic i_rd, input logic [31:0] i_addr,
    input logic d_rd, input logic d_wr, input logic [31:0] d_addr,
    input logic [31:0] d_wdata, input logic m_wait, input logic [31:0] m_rdata,
    input logic e_rd, input logic e_wr, input logic [31:0] e_addr,
    input logic [31:0] e_wdata, input logic e_iw, input logic e_dw,
    input logic e_g);
    vec_t v;
    v.i_rd = i_rd;  v.i_addr = i_addr;
    v.d_rd = d_rd;  v.d_wr = d_wr;  v.d_addr = d_addr;  v.d_wdata = d_wdata;
    v.m_wait = m_wait;  v.m_rdata = m_rdata;
    v.e_rd = e_rd;  v.e_wr = e_wr;  v.e_addr = e_addr;  v.e_wdata = e_wdata;
    v.e_iw = e_iw;  v.e_dw = e_dw;  v.e_g = e_g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic i_rd, input logic [31:0] i_addr,
                       input logic d_rd, input logic d_wr, input logic [31:0] d_addr,
                       input logic [31:0] d_wdata, input logic m_wait,
                       input logic [31:0] m_rdata);
    i_if.rd = i_rd;  i_if.address_r = i_addr;
    d_if.rd = d_rd;  d_if.wr = d_wr;  d_if.address_r = d_addr;  d_if.data_w = d_wdata;
    m_if.wait_req = m_wait;  m_if.data_r = m_rdata;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " mem.rd"},     32'(m_if.rd), 32'd0);
    chk({tag, " mem.wr"},     32'(m_if.wr), 32'd0);
    chk({tag, " mem.addr"},   m_if.address_r, 32'd0);
    chk({tag, " mem.data_w"}, m_if.data_w, 32'd0);
    chk({tag, " i.wait"},     32'(i_if.wait_req), 32'd1);
    chk({tag, " d.wait"},     32'(d_if.wait_req), 32'd1);
    chk({tag, " grant"},      32'(grant_data), 32'd0);
    chk({tag, " i.data_r"},   i_if.data_r, 32'd0);
    chk({tag, " d.data_r"},   d_if.data_r, 32'd0);
  endtask

  initial begin
    logic exp_g;
    i_if.wr = 1'b0;
    i_if.data_w = '0;

    // row: i_rd,i_addr, d_rd,d_wr,d_addr,d_wdata, m_wait,m_rdata |
    //      e_rd,e_wr,e_addr,e_wdata, e_iw,e_dw,e_g
    vecs[0]  = mkv(1, 32'h000, 0, 0, 32'h000, 32'h0,    0, 32'h1111,  1, 0, 32'h000, 32'h0,    0, 0, 0);
    vecs[1]  = mkv(1, 32'h010, 1, 0, 32'h200, 32'h0,    0, 32'h2222,  1, 0, 32'h200, 32'h0,    1, 0, 1);
    vecs[2]  = mkv(1, 32'h010, 0, 0, 32'h000, 32'h0,    0, 32'h3333,  1, 0, 32'h010, 32'h0,    0, 0, 0);
    vecs[3]  = mkv(1, 32'h010, 0, 0, 32'h000, 32'h0,    1, 32'h0,     1, 0, 32'h010, 32'h0,    1, 0, 0);
    vecs[4]  = mkv(1, 32'h010, 0, 1, 32'h300, 32'hAA,   1, 32'h0,     1, 0, 32'h010, 32'h0,    1, 1, 0);
    vecs[5]  = mkv(1, 32'h010, 0, 1, 32'h300, 32'hAA,   1, 32'h0,     1, 0, 32'h010, 32'h0,    1, 1, 0);
    vecs[6]  = mkv(1, 32'h010, 0, 1, 32'h300, 32'hAA,   0, 32'h4444,  1, 0, 32'h010, 32'h0,    0, 1, 0);
    vecs[7]  = mkv(1, 32'h010, 0, 1, 32'h300, 32'hAA,   0, 32'h0,     0, 1, 32'h300, 32'hAA,   1, 0, 1);
    vecs[8]  = mkv(1, 32'h020, 1, 0, 32'h400, 32'h0,    1, 32'h0,     1, 0, 32'h400, 32'h0,    1, 1, 1);
    vecs[9]  = mkv(1, 32'h020, 1, 0, 32'h400, 32'h0,    1, 32'h0,     1, 0, 32'h400, 32'h0,    1, 1, 1);
    vecs[10] = mkv(1, 32'h020, 0, 0, 32'h000, 32'h0,    1, 32'h0,     0, 0, 32'h000, 32'h0,    1, 0, 0);
    vecs[11] = mkv(1, 32'h020, 0, 0, 32'h000, 32'h0,    0, 32'h5555,  1, 0, 32'h020, 32'h0,    0, 0, 0);
    vecs[12] = mkv(0, 32'h000, 0, 0, 32'h000, 32'h0,    0, 32'h0,     0, 0, 32'h000, 32'h0,    0, 0, 0);
    vecs[13] = mkv(0, 32'h000, 0, 1, 32'h500, 32'h1234, 0, 32'h0,     0, 1, 32'h500, 32'h1234, 0, 0, 1);

    // Reset held 3 cycles with both masters requesting.
    areset_n = 1'b0;
    drive(1, 32'h10, 1, 1, 32'h200, 32'h77, 0, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outs("reset");
    @(posedge clk);
    #1;
    areset_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      drive(vecs[r].i_rd, vecs[r].i_addr, vecs[r].d_rd, vecs[r].d_wr,
            vecs[r].d_addr, vecs[r].d_wdata, vecs[r].m_wait, vecs[r].m_rdata);
      #3;
      chk($sformatf("row%0d mem.rd", r),     32'(m_if.rd), 32'(vecs[r].e_rd));
      chk($sformatf("row%0d mem.wr", r),     32'(m_if.wr), 32'(vecs[r].e_wr));
      chk($sformatf("row%0d mem.addr", r),   m_if.address_r, vecs[r].e_addr);
      chk($sformatf("row%0d mem.data_w", r), m_if.data_w, vecs[r].e_wdata);
      chk($sformatf("row%0d i.wait", r),     32'(i_if.wait_req), 32'(vecs[r].e_iw));
      chk($sformatf("row%0d d.wait", r),     32'(d_if.wait_req), 32'(vecs[r].e_dw));
      chk($sformatf("row%0d grant", r),      32'(grant_data), 32'(vecs[r].e_g));
      chk($sformatf("row%0d i.data_r", r),   i_if.data_r, vecs[r].m_rdata);
      chk($sformatf("row%0d d.data_r", r),   d_if.data_r, vecs[r].m_rdata);
      @(posedge clk);
      #1;
    end

    // Continuous data and instr reads, memory never stalls.
    for (int k = 0; k < 15; k++) begin
      drive(1, 32'h60, 1, 0, 32'h600, 32'h0, 0, 32'h0);
      #3;
`ifdef QRISC32_ARB_FAIRNESS_EN
      exp_g = (k % 5 != 4);
`else
      exp_g = 1'b1;
`endif
      chk($sformatf("stream%0d grant", k),  32'(grant_data), 32'(exp_g));
      chk($sformatf("stream%0d mem.addr", k), m_if.address_r, exp_g ? 32'h600 : 32'h60);
      chk($sformatf("stream%0d i.wait", k), 32'(i_if.wait_req), 32'(exp_g));
      @(posedge clk);
      #1;
    end

    // Async reset while a data read is locked.
    drive(0, 32'h0, 1, 0, 32'h700, 32'h0, 1, 32'h0);
    #3;
    chk("lockd enter grant", 32'(grant_data), 32'd1);
    @(posedge clk);
    #1;
    chk("lockd hold grant", 32'(grant_data), 32'd1);
    chk("lockd hold addr",  m_if.address_r, 32'h700);
    #2;
    areset_n = 1'b0;
    #1;
    chk_reset_outs("midlock");
    @(posedge clk);
    #1;
    drive(1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    areset_n = 1'b1;
    #2;
    chk("post-reset mem.rd",   32'(m_if.rd), 32'd1);
    chk("post-reset mem.addr", m_if.address_r, 32'h40);
    chk("post-reset i.wait",   32'(i_if.wait_req), 32'd0);
    chk("post-reset grant",    32'(grant_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
